// File: rtl/dm_lsu_ctrl_if.sv
// ---------------------------------------------------------------------------
// dm_lsu_ctrl_if
//   Bundles the core-side request/response handshake and the word-RAM port
//   of the load/store sequencer.
//
//   Request  : req_valid, req_ready, req_addr, req_we, req_ctrl, req_wdata
//   Response : rsp_valid, rsp_rdata, rsp_err
//   RAM      : mem_en, mem_we, mem_addr[AW-1:0], mem_be, mem_wdata, mem_rdata
//
//   slave  : the controller's view (accepts requests, drives the RAM port)
//   master : the environment's view (core issues requests, RAM answers)
// ---------------------------------------------------------------------------
interface dm_lsu_ctrl_if #(
  parameter int unsigned AW = 6
);
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_addr;
  logic          req_we;
  logic [2:0]    req_ctrl;
  logic [31:0]   req_wdata;

  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  req_valid, req_addr, req_we, req_ctrl, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_en, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_addr, req_we, req_ctrl, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_en, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/dm_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// dm_lsu_ctrl
//   Load/store sequencer between the core memory stage and a synchronous
//   32-bit word RAM with byte enables. One byte-addressed access is accepted
//   per handshake; loads return sign- or zero-extended data.
//
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset
//     bus    - dm_lsu_ctrl_if.slave (request, response and RAM port)
//
//   req_ctrl: 000 byte, 001 half, 010 word, 100 byte unsigned,
//             101 half unsigned; anything else (and unsigned stores) is
//             rejected with rsp_err.
//
//   Build option DM_MISALIGN_SPLIT_EN:
//     defined   - accesses crossing a word boundary are split into two RAM
//                 accesses (word wa, then word wa+1 modulo 2^AW)
//     undefined - such accesses are rejected; no second access state exists
// ---------------------------------------------------------------------------
module dm_lsu_ctrl #(
  parameter int unsigned AW = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  dm_lsu_ctrl_if.slave bus
);

`ifdef DM_MISALIGN_SPLIT_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    DONE = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    DONE = 2'd3
  } state_e;
`endif

  state_e        state_q, state_d;
  logic [1:0]    off_q,   off_d;
  logic [AW-1:0] wa_q,    wa_d;
  logic          we_q,    we_d;
  logic [2:0]    ctrl_q,  ctrl_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          err_q,   err_d;
`ifdef DM_MISALIGN_SPLIT_EN
  logic [31:0]   lo_q,    lo_d;
`endif

  // Address bits above the RAM index are deliberately ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[31:AW+2];

  // ---------------------------------------------------------------------
  // Incoming request decode
  // ---------------------------------------------------------------------
  logic [1:0] req_off;
  logic       req_bad_code;
  logic       req_split;
  logic       req_illegal;

  assign req_off      = bus.req_addr[1:0];
  assign req_bad_code = (bus.req_ctrl == 3'b011) || (bus.req_ctrl == 3'b110) ||
                        (bus.req_ctrl == 3'b111) || (bus.req_we && bus.req_ctrl[2]);
  // Half at offset 3 or any unaligned word crosses into the next word.
  assign req_split    = ((bus.req_ctrl[1:0] == 2'b01) && (req_off == 2'd3)) ||
                        ((bus.req_ctrl[1:0] == 2'b10) && (req_off != 2'd0));
`ifdef DM_MISALIGN_SPLIT_EN
  assign req_illegal  = req_bad_code;
`else
  assign req_illegal  = req_bad_code || req_split;
`endif

  // ---------------------------------------------------------------------
  // Latched-request helpers
  // ---------------------------------------------------------------------
  logic [3:0] sz_mask;
  logic [4:0] sh;          // byte offset expressed in bits

  always_comb begin
    unique case (ctrl_q[1:0])
      2'b00:   sz_mask = 4'b0001;
      2'b01:   sz_mask = 4'b0011;
      default: sz_mask = 4'b1111;
    endcase
  end

  assign sh = {off_q, 3'b000};

`ifdef DM_MISALIGN_SPLIT_EN
  logic       cur_split;
  logic [5:0] hi_sh;
  assign cur_split = ((ctrl_q[1:0] == 2'b01) && (off_q == 2'd3)) ||
                     ((ctrl_q[1:0] == 2'b10) && (off_q != 2'd0));
  assign hi_sh     = 6'd32 - {1'b0, sh};
`endif

  // ---------------------------------------------------------------------
  // Load data alignment and extension
  // ---------------------------------------------------------------------
  logic [31:0] raw;
  logic [31:0] ext;
  logic        sx;

  always_comb begin
    raw = bus.mem_rdata >> sh;
`ifdef DM_MISALIGN_SPLIT_EN
    // Split load: lo_q holds word wa, mem_rdata now holds word wa+1.
    if (cur_split) begin
      raw = 32'({bus.mem_rdata, lo_q} >> sh);
    end
`endif
    sx = ~ctrl_q[2];
    unique case (ctrl_q[1:0])
      2'b00:   ext = {{24{sx & raw[7]}},  raw[7:0]};
      2'b01:   ext = {{16{sx & raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      off_q   <= '0;
      wa_q    <= '0;
      we_q    <= 1'b0;
      ctrl_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
`ifdef DM_MISALIGN_SPLIT_EN
      lo_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      wa_q    <= wa_d;
      we_q    <= we_d;
      ctrl_q  <= ctrl_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
`ifdef DM_MISALIGN_SPLIT_EN
      lo_q    <= lo_d;
`endif
    end
  end

  // ---------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    off_d         = off_q;
    wa_d          = wa_q;
    we_d          = we_q;
    ctrl_d        = ctrl_q;
    wdata_d       = wdata_q;
    err_d         = err_q;
`ifdef DM_MISALIGN_SPLIT_EN
    lo_d          = lo_q;
`endif
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = '0;
    bus.rsp_err   = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_be    = '0;
    bus.mem_wdata = '0;

    unique case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          off_d   = req_off;
          wa_d    = bus.req_addr[AW+1:2];
          we_d    = bus.req_we;
          ctrl_d  = bus.req_ctrl;
          wdata_d = bus.req_wdata;
          err_d   = req_illegal;
          state_d = req_illegal ? DONE : ACC0;
        end
      end

      ACC0: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_addr  = wa_q;
        bus.mem_be    = sz_mask << off_q;
        bus.mem_wdata = wdata_q << sh;
`ifdef DM_MISALIGN_SPLIT_EN
        state_d       = cur_split ? ACC1 : DONE;
`else
        state_d       = DONE;
`endif
      end

`ifdef DM_MISALIGN_SPLIT_EN
      ACC1: begin
        lo_d          = bus.mem_rdata;
        bus.mem_en    = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_addr  = wa_q + 1'b1;
        // Upper nibble of the lane mask shifted past the word boundary.
        bus.mem_be    = 4'(({4'b0000, sz_mask} << off_q) >> 4);
        bus.mem_wdata = wdata_q >> hi_sh;
        state_d       = DONE;
      end
`endif

      DONE: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = err_q;
        if (!err_q && !we_q) begin
          bus.rsp_rdata = ext;
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dm_lsu_ctrl.sv
module tb_dm_lsu_ctrl;

  logic clk;
  logic rst_n;

  dm_lsu_ctrl_if #(.AW(6)) bus ();

  dm_lsu_ctrl #(.AW(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // -------------------------------------------------------------------
  // Word RAM attached to the DUT, and a flat byte-array reference model
  // -------------------------------------------------------------------
  function automatic logic [31:0] init_word(input int unsigned w);
    return (w * 32'h0103_0507) ^ 32'h9E37_79B9;
  endfunction

  logic [31:0] ram [64];
  bit          ram_loaded = 1'b0;

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int w = 0; w < 64; w++) ram[w] <= init_word(w);
      ram_loaded <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int l = 0; l < 4; l++)
          if (bus.mem_be[l]) ram[bus.mem_addr][8*l +: 8] <= bus.mem_wdata[8*l +: 8];
      end else begin
        bus.mem_rdata <= ram[bus.mem_addr];
      end
    end
  end

  logic [7:0] ref_mem [256];

  function automatic bit legal(input logic w, input logic [2:0] c);
    return (c inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) && !(w && c[2]);
  endfunction

  function automatic int unsigned size_of(input logic [2:0] c);
    return (c[1:0] == 2'b00) ? 1 : (c[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] c);
    logic [31:0] v;
    int unsigned sz;
    sz = size_of(c);
    v  = '0;
    for (int i = 0; i < int'(sz); i++) v[8*i +: 8] = ref_mem[(a + i) & 32'hFF];
    if (!c[2] && sz < 4 && v[8*sz-1])
      for (int i = int'(sz); i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  // Results of the most recent transaction
  logic [31:0] last_rdata;
  logic        last_err;
  int unsigned last_lat;
  int unsigned n_acc;
  logic [5:0]  acc_addr [2];
  logic [3:0]  acc_be   [2];
  logic [31:0] acc_wd   [2];
  logic        acc_we   [2];

  // Issue one request from a negedge with the DUT idle; check it against
  // the byte-level model; return at a negedge with the DUT idle again.
  task automatic do_req(input logic [31:0] a, input logic w, input logic [2:0] c,
                        input logic [31:0] wd, input bit noise);
    bit          ok, sp, done;
    int unsigned sz, exp_acc, cyc;
    logic [3:0]  ebe [2];
    logic [31:0] ewd [2];
    logic [5:0]  wa0;
    logic [31:0] b;
    int unsigned k;

    ok = legal(w, c);
    sz = size_of(c);
    sp = ok && (((a & 32'd3) + sz) > 4);
`ifndef DM_MISALIGN_SPLIT_EN
    if (sp) ok = 1'b0;
`endif
    exp_acc = !ok ? 0 : (sp ? 2 : 1);

    wa0 = a[7:2];
    ebe[0] = '0; ebe[1] = '0; ewd[0] = '0; ewd[1] = '0;
    for (int i = 0; i < int'(sz); i++) begin
      b = (a + i) & 32'hFF;
      k = (b[7:2] == wa0) ? 0 : 1;
      ebe[k][b[1:0]] = 1'b1;
      ewd[k][8*b[1:0] +: 8] = wd[8*i +: 8];
    end

    check("ready_idle", {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_we    = w;
    bus.req_ctrl  = c;
    bus.req_wdata = wd;
    @(posedge clk);

    n_acc = 0; cyc = 0; done = 1'b0;
    last_rdata = '0; last_err = 1'b0;
    while (!done && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("busy_ready", {31'b0, bus.req_ready}, 32'd0);
      if (bus.mem_en) begin
        if (n_acc < 2) begin
          acc_addr[n_acc] = bus.mem_addr;
          acc_be[n_acc]   = bus.mem_be;
          acc_wd[n_acc]   = bus.mem_wdata;
          acc_we[n_acc]   = bus.mem_we;
        end
        n_acc++;
      end
      if (bus.rsp_valid) begin
        done       = 1'b1;
        last_rdata = bus.rsp_rdata;
        last_err   = bus.rsp_err;
      end
      if (!done && noise) begin
        bus.req_valid = 1'b1;
        bus.req_addr  = $urandom;
        bus.req_we    = 1'($urandom_range(0, 1));
        bus.req_ctrl  = 3'($urandom_range(0, 7));
        bus.req_wdata = $urandom;
      end else begin
        bus.req_valid = 1'b0;
      end
    end
    last_lat = cyc;

    if (!done) begin
      check("rsp_timeout", 32'd0, 32'd1);
      return;
    end

    check("latency", last_lat, exp_acc + 1);
    check("rsp_err", {31'b0, last_err}, {31'b0, !ok});
    check("rsp_rdata", last_rdata, (ok && !w) ? model_load(a, c) : 32'd0);
    check("n_access", n_acc, exp_acc);
    for (int i = 0; i < 2; i++) begin
      if (i < int'(exp_acc) && i < int'(n_acc)) begin
        check("acc_addr", {26'b0, acc_addr[i]}, {26'b0, 6'(wa0 + i)});
        check("acc_be", {28'b0, acc_be[i]}, {28'b0, ebe[i]});
        check("acc_we", {31'b0, acc_we[i]}, {31'b0, w});
        if (w) check("acc_wdata", acc_wd[i] & {{8{acc_be[i][3]}}, {8{acc_be[i][2]}},
                                               {8{acc_be[i][1]}}, {8{acc_be[i][0]}}}, ewd[i]);
      end
    end

    @(negedge clk);
    check("rsp_pulse", {31'b0, bus.rsp_valid}, 32'd0);
    check("ready_back", {31'b0, bus.req_ready}, 32'd1);

    if (ok && w)
      for (int i = 0; i < int'(sz); i++) ref_mem[(a + i) & 32'hFF] = wd[8*i +: 8];
  endtask

  initial begin
    for (int w = 0; w < 64; w++) begin
      logic [31:0] iw;
      iw = init_word(w);
      for (int l = 0; l < 4; l++) ref_mem[4*w + l] = iw[8*l +: 8];
    end

    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_we    = 1'b0;
    bus.req_ctrl  = '0;
    bus.req_wdata = '0;

    #3;
    check("rst_ready", {31'b0, bus.req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("rst_mem_en", {31'b0, bus.mem_en}, 32'd0);
    check("rst_mem_be", {28'b0, bus.mem_be}, 32'd0);
    check("rst_mem_addr", {26'b0, bus.mem_addr}, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_rdata", bus.rsp_rdata, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Aligned word store and read-back
    do_req(32'h08, 1'b1, 3'b010, 32'hDEADBEEF, 1'b0);
    check("t1_addr", {26'b0, acc_addr[0]}, 32'd2);
    check("t1_be", {28'b0, acc_be[0]}, 32'hF);
    check("t1_lat", last_lat, 32'd2);
    do_req(32'h08, 1'b0, 3'b010, 32'h0, 1'b0);
    check("t1_rdata", last_rdata, 32'hDEADBEEF);

    // Sign/zero extension
    do_req(32'h10, 1'b1, 3'b010, 32'h000080F0, 1'b0);
    do_req(32'h10, 1'b0, 3'b000, 32'h0, 1'b0);
    check("t2_lb", last_rdata, 32'hFFFFFFF0);
    do_req(32'h10, 1'b0, 3'b100, 32'h0, 1'b0);
    check("t2_lbu", last_rdata, 32'h000000F0);
    do_req(32'h10, 1'b0, 3'b001, 32'h0, 1'b0);
    check("t2_lh", last_rdata, 32'hFFFF80F0);

    // Upper-half store
    do_req(32'h06, 1'b1, 3'b001, 32'h00001234, 1'b0);
    check("t3_be", {28'b0, acc_be[0]}, 32'hC);
    check("t3_wdata", acc_wd[0], 32'h12340000);
    check("t3_nacc", n_acc, 32'd1);

    // Misaligned word store
    do_req(32'h0D, 1'b1, 3'b010, 32'hAABBCCDD, 1'b0);
`ifdef DM_MISALIGN_SPLIT_EN
    check("t4_a0", {26'b0, acc_addr[0]}, 32'd3);
    check("t4_be0", {28'b0, acc_be[0]}, 32'hE);
    check("t4_wd0", acc_wd[0], 32'hBBCCDD00);
    check("t4_a1", {26'b0, acc_addr[1]}, 32'd4);
    check("t4_be1", {28'b0, acc_be[1]}, 32'h1);
    check("t4_wd1", acc_wd[1], 32'h000000AA);
    do_req(32'h0D, 1'b0, 3'b010, 32'h0, 1'b0);
    check("t4_rdata", last_rdata, 32'hAABBCCDD);
    check("t4_lat", last_lat, 32'd3);
`else
    check("t4_err", {31'b0, last_err}, 32'd1);
`endif

    // Wrap-around split and rejects
    do_req(32'hFF, 1'b0, 3'b001, 32'h0, 1'b0);
`ifdef DM_MISALIGN_SPLIT_EN
    check("t5_a0", {26'b0, acc_addr[0]}, 32'd63);
    check("t5_a1", {26'b0, acc_addr[1]}, 32'd0);
`else
    check("t5_wrap_err", {31'b0, last_err}, 32'd1);
`endif
    do_req(32'h20, 1'b1, 3'b101, 32'h5555AAAA, 1'b0);
    check("t5_sthu_err", {31'b0, last_err}, 32'd1);
    check("t5_sthu_lat", last_lat, 32'd1);
    check("t5_sthu_nacc", n_acc, 32'd0);
`ifndef DM_MISALIGN_SPLIT_EN
    do_req(32'h01, 1'b0, 3'b010, 32'h0, 1'b0);
    check("t5_lw_err", {31'b0, last_err}, 32'd1);
    check("t5_lw_rdata", last_rdata, 32'd0);
`endif

    // Reset in the middle of a load
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_ctrl  = 3'b010;
`ifdef DM_MISALIGN_SPLIT_EN
    bus.req_addr  = 32'h0E;
`else
    bus.req_addr  = 32'h0C;
`endif
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
`ifdef DM_MISALIGN_SPLIT_EN
    @(negedge clk);
`endif
    check("t6_pre_en", {31'b0, bus.mem_en}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_en", {31'b0, bus.mem_en}, 32'd0);
    check("t6_be", {28'b0, bus.mem_be}, 32'd0);
    check("t6_addr", {26'b0, bus.mem_addr}, 32'd0);
    check("t6_rsp", {31'b0, bus.rsp_valid}, 32'd0);
    check("t6_ready", {31'b0, bus.req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("t6_no_rsp", {31'b0, bus.rsp_valid}, 32'd0);
    end
    check("t6_ready_after", {31'b0, bus.req_ready}, 32'd1);

    // Randomized traffic, concentrated on a few words plus the wrap region
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ra;
      if ($urandom_range(0, 3) == 0) ra = 32'hF0 + $urandom_range(0, 15);
      else                           ra = $urandom_range(0, 63);
      ra = ra | ({$urandom} & 32'hFFFF_FF00);
      do_req(ra, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
             1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/dm_lsu_ctrl.md
Name: dm_lsu_ctrl

Overview:
- Load/store sequencer between the core's memory stage and the word-organised data memory.
- Accepts one byte-addressed load/store per handshake, encoded with the 3-bit DmCtrl size/sign code.
- Drives a synchronous 32-bit word RAM with byte enables and returns sign- or zero-extended load data.
- Optionally splits misaligned halfword/word accesses into two RAM accesses.

Parameters:
AW, 6, word-address width of the data RAM (64 words); RAM word index = req_addr[AW+1:2]

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  request present
req_ready  out  1  controller idle, can accept request
req_addr  in  32  byte address
req_we  in  1  1=store, 0=load
req_ctrl  in  3  000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  request rejected, no RAM write performed
mem_en  out  1  RAM access strobe
mem_we  out  1  RAM write
mem_addr  out  AW  RAM word index
mem_be  out  4  byte enables, bit i = byte lane i
mem_wdata  out  32  lane-aligned write data
mem_rdata  in  32  RAM read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Reset: asynchronous on rst_n low.
  - Outputs while in reset: state IDLE, req_ready=1, all other outputs 0, captured registers cleared.
  - Reset mid-operation drops the request with no response.
  - A RAM write already strobed before reset is not undone.
- States: IDLE, ACC0, ACC1, DONE.
- IDLE: req_ready=1. On req_valid at cycle T:
  - Latch addr, we, ctrl, wdata; off = addr[1:0]; wa = addr[AW+1:2].
  - Illegal request goes to DONE at T+1: ctrl in {011, 110, 111}, or we=1 with ctrl 100/101.
  - Otherwise go to ACC0 at T+1.
- ACC0: mem_en=1, mem_we=we, mem_addr=wa.
  - Byte enables: mem_be = (sz_mask << off)[3:0], where sz_mask = 0001 / 0011 / 1111 for byte / half / word.
  - Write data: mem_wdata = (wdata << 8*off)[31:0].
  - Split access (half with off=3, or word with off!=0) goes to ACC1; otherwise DONE.
- ACC1:
  - Capture mem_rdata into lo_q.
  - mem_en=1, mem_we=we, mem_addr=wa+1 (wraps modulo 2^AW).
  - mem_be = (sz_mask << off)[7:4]; mem_wdata = wdata >> 8*(4-off).
  - Go to DONE.
- DONE: rsp_valid=1 for one cycle, then IDLE.
  - Load data: raw = {mem_rdata, hi_src} >> 8*off, where hi_src = lo_q if split, else mem_rdata used alone.
  - Extension: select byte/half, sign-extend for 000/001, zero-extend for 100/101; word passes through.
- Latency (request accepted at T):
  - rsp_valid at T+2 for aligned, T+3 for split, T+1 for illegal.
  - req_ready returns 1 one cycle after rsp_valid.
- req_ready=0 in every state except IDLE; req_valid outside IDLE is ignored.
- Byte accesses never split. Aligned word (off=0) uses be=1111.
- mem_en=0 outside ACC0/ACC1.
- Outputs in IDLE: mem_be, mem_wdata and mem_addr are 0.

Optional Feature:
- Macro: DM_MISALIGN_SPLIT_EN.
- Defined: split accesses behave as above.
- Undefined: any access that would split is illegal (rsp_err=1 at T+1, no mem_en); the ACC1 state and lo_q are not built.

Test Plan:
1. Store word 0xDEADBEEF at addr 0x08, then load word (ctrl 010) at 0x08. Store: mem_addr=2, be=1111 at T+1, rsp_valid at T+2. Load: rsp_rdata=0xDEADBEEF at T+2, rsp_err=0.
2. Word 0x000080F0 at addr 0x10. Load byte at 0x10 (ctrl 000) -> 0xFFFFFFF0. Load byte unsigned at 0x10 (ctrl 100) -> 0x000000F0. Load half at 0x10 (ctrl 001) -> 0xFFFF80F0.
3. Store half 0x1234 at addr 0x06 (ctrl 001). Expect mem_be=1100, mem_wdata=0x12340000, single access, rsp_valid at T+2.
4. Split store, macro defined: store word 0xAABBCCDD at addr 0x0D.
   - Access 1: mem_addr=3, be=1110, wdata=0xBBCCDD00.
   - Access 2: mem_addr=4, be=0001, wdata=0x000000AA.
   - Reading it back at 0x0D returns 0xAABBCCDD at T+3.
5. Wrap and reject: split half load at addr 0xFF (AW=6) accesses word 63 then word 0. Store with ctrl 101 -> rsp_err=1 at T+1, mem_en stays 0. Without the macro, load word at 0x01 -> rsp_err=1, rsp_rdata=0.
6. Assert rst_n low during ACC1 of a split load. All outputs go to 0 immediately, no rsp_valid follows, and req_ready=1 after release.
